mchk_scbd: RTL and testbench

Multi-channel scoreboard/checker for the AudioNet verification environment. It is the parametrised successor of the single-stream scoreboard + checker pair, used in the top-level bench on the serial clock domain. It holds per-channel FIFOs of expected parallel words with a compare mask, pops and compares on each actual word, and keeps saturating match, mismatch, unexpected, overflow and timeout counters. Both rx and tx monitors on any number of TDM channels can be checked through one instance.

---
 rtl/mchk_scbd.sv | 116 +++++++++++
 tb/tb_mchk_scbd.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mchk_scbd.sv
// mchk_scbd: multi-channel expected/actual scoreboard with masked compare and saturating event counters
module mchk_scbd #(
   parameter int WIDTH   = 256,
   parameter int ADDR    = 2,
   parameter int CHANS   = 2,
   parameter int CW      = 1,
   parameter int CNTW    = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             exp_push,
   input  logic [CW-1:0]    exp_chan,
   input  logic [WIDTH-1:0] exp_data,
   input  logic [WIDTH-1:0] exp_mask,
   input  logic             act_valid,
   input  logic [CW-1:0]    act_chan,
   input  logic [WIDTH-1:0] act_data,
   output logic [CHANS-1:0] exp_empty,
   output logic [CHANS-1:0] exp_full,
   output logic             err_pulse,
   output logic [CW-1:0]    err_chan,
   output logic [CNTW-1:0]  match_cnt,
   output logic [CNTW-1:0]  mism_cnt,
   output logic [CNTW-1:0]  unexp_cnt,
   output logic [CNTW-1:0]  ovf_cnt,
   output logic [CNTW-1:0]  tmo_cnt,
   output logic             test_pass,
   output logic             idle
);
   localparam int DEPTH = 2 ** ADDR;
   localparam int AW    = $clog2(TIMEOUT + 1);

   logic [2*WIDTH-1:0] mem [CHANS*DEPTH];
   logic [ADDR:0]      rd  [CHANS];
   logic [ADDR:0]      wr  [CHANS];
   logic [AW-1:0]      age [CHANS];
   logic [2*WIDTH-1:0] head;
   logic [CHANS-1:0]   tmo_v;
   logic [CW:0]        tmo_n;
   logic [CW-1:0]      tmo_ch;
   logic               act_ok, exp_ok, hit, match, mism, unexp, acc, ovf, flush;

   function automatic logic [CNTW-1:0] sat(input logic [CNTW-1:0] a, input logic [CW:0] b);
      logic [CNTW:0] s;
      s = {1'b0, a} + (CNTW+1)'(b);
      return s[CNTW] ? '1 : s[CNTW-1:0];
   endfunction

   // decode FIFO status, classify this cycle's push/act and collect channel timeouts
   always_comb begin
      for (int c = 0; c < CHANS; c++) begin
         exp_empty[c] = rd[c] == wr[c];
         exp_full[c]  = rd[c] == {~wr[c][ADDR], wr[c][ADDR-1:0]};
      end
      flush  = rst || clear;
      act_ok = act_valid && ({1'b0, act_chan} < (CW+1)'(CHANS));
      exp_ok = exp_push && ({1'b0, exp_chan} < (CW+1)'(CHANS));
      hit    = act_ok && !exp_empty[act_chan];
      head   = mem[{act_chan, rd[act_chan][ADDR-1:0]}];
      match  = hit && (((act_data ^ head[WIDTH-1:0]) & head[2*WIDTH-1:WIDTH]) == '0);
      mism   = hit && !match;
      unexp  = act_valid && !hit;
      // a full channel still takes the push when the same cycle pops it
      acc    = exp_ok && (!exp_full[exp_chan] || (hit && act_chan == exp_chan));
      ovf    = exp_push && !acc;
      tmo_n  = '0;
      tmo_ch = '0;
      for (int c = CHANS - 1; c >= 0; c--) begin
         tmo_v[c] = !exp_empty[c] && !(hit && act_chan == CW'(c)) && age[c] == AW'(TIMEOUT - 2);
         tmo_ch   = tmo_v[c] ? CW'(c) : tmo_ch;
         tmo_n    = tmo_n + (CW+1)'(tmo_v[c]);
      end
   end

   // expected-word storage, indexed {channel, pointer}
   always_ff @(posedge clk) begin
      if (acc && !flush) mem[{exp_chan, wr[exp_chan][ADDR-1:0]}] <= {exp_mask, exp_data};
   end

   // pointers, head age, counters and error reporting
   always_ff @(posedge clk) begin
      if (flush) begin
         for (int c = 0; c < CHANS; c++) begin
            rd[c]  <= '0;
            wr[c]  <= '0;
            age[c] <= '0;
         end
         match_cnt <= '0;
         mism_cnt  <= '0;
         unexp_cnt <= '0;
         ovf_cnt   <= '0;
         tmo_cnt   <= '0;
         err_pulse <= 1'b0;
         err_chan  <= '0;
      end else begin
         for (int c = 0; c < CHANS; c++) begin
            if (acc && exp_chan == CW'(c)) wr[c] <= wr[c] + 1'b1;
            if (hit && act_chan == CW'(c)) rd[c] <= rd[c] + 1'b1;
            age[c] <= (exp_empty[c] || (hit && act_chan == CW'(c))) ? '0 :
                      (age[c] == AW'(TIMEOUT)) ? age[c] : age[c] + 1'b1;
         end
         match_cnt <= sat(match_cnt, (CW+1)'(match));
         mism_cnt  <= sat(mism_cnt, (CW+1)'(mism));
         unexp_cnt <= sat(unexp_cnt, (CW+1)'(unexp));
         ovf_cnt   <= sat(ovf_cnt, (CW+1)'(ovf));
         tmo_cnt   <= sat(tmo_cnt, tmo_n);
         err_pulse <= mism || unexp || ovf || tmo_n != '0;
         err_chan  <= (mism || unexp) ? act_chan : ovf ? exp_chan : (tmo_n != '0) ? tmo_ch : err_chan;
      end
   end

   assign test_pass = (mism_cnt | unexp_cnt | ovf_cnt | tmo_cnt) == '0;
   assign idle      = &exp_empty;
endmodule

// File: tb/tb_mchk_scbd.sv
// tb_mchk_scbd: directed scoreboard-model bench for mchk_scbd
module tb_mchk_scbd;
   localparam int W = 256;

   logic          clk = 1'b0, rst = 1'b1, clear = 1'b0;
   logic          exp_push = 1'b0, act_valid = 1'b0;
   logic [0:0]    exp_chan = '0, act_chan = '0;
   logic [W-1:0]  exp_data = '0, exp_mask = '0, act_data = '0;
   logic [1:0]    exp_empty, exp_full;
   logic          err_pulse, test_pass, idle;
   logic [0:0]    err_chan;
   logic [3:0]    match_cnt, mism_cnt, unexp_cnt, ovf_cnt, tmo_cnt;

   mchk_scbd #(.WIDTH(W), .ADDR(2), .CHANS(2), .CW(1), .CNTW(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .exp_push(exp_push), .exp_chan(exp_chan), .exp_data(exp_data), .exp_mask(exp_mask),
      .act_valid(act_valid), .act_chan(act_chan), .act_data(act_data),
      .exp_empty(exp_empty), .exp_full(exp_full), .err_pulse(err_pulse), .err_chan(err_chan),
      .match_cnt(match_cnt), .mism_cnt(mism_cnt), .unexp_cnt(unexp_cnt), .ovf_cnt(ovf_cnt),
      .tmo_cnt(tmo_cnt), .test_pass(test_pass), .idle(idle)
   );

   always #5 clk = ~clk;

   int             checks = 0, failures = 0;
   int             m_match = 0, m_mism = 0, m_unexp = 0, m_ovf = 0, m_tmo = 0, m_echan = 0;
   logic           m_ev = 1'b0, tev = 1'b0;
   logic [2*W-1:0] q [2][$];
   localparam logic [W-1:0] ONES = '1;

   function automatic logic [W-1:0] rep(input logic [7:0] b);
      return {32{b}};
   endfunction

   function automatic int sat(input int v);
      return v > 15 ? 15 : v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_state();
      chk("match_cnt", 32'(match_cnt), 32'(m_match));
      chk("mism_cnt", 32'(mism_cnt), 32'(m_mism));
      chk("unexp_cnt", 32'(unexp_cnt), 32'(m_unexp));
      chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
      chk("tmo_cnt", 32'(tmo_cnt), 32'(m_tmo));
      chk("err_pulse", 32'(err_pulse), 32'(m_ev));
      chk("err_chan", 32'(err_chan), 32'(m_echan));
      chk("exp_empty", 32'(exp_empty), {30'd0, q[1].size() == 0, q[0].size() == 0});
      chk("exp_full", 32'(exp_full), {30'd0, q[1].size() == 4, q[0].size() == 4});
      chk("test_pass", 32'(test_pass), 32'((m_mism | m_unexp | m_ovf | m_tmo) == 0));
      chk("idle", 32'(idle), 32'(q[0].size() == 0 && q[1].size() == 0));
   endtask

   // drive one cycle, predict with the queue model, then check after the edge
   task automatic step(input bit p, input int pc, input logic [W-1:0] pd, input logic [W-1:0] pm,
                       input bit a, input int ac, input logic [W-1:0] ad);
      logic [2*W-1:0] h;
      bit aerr, perr;
      aerr = 0;
      perr = 0;
      exp_push = p; exp_chan = 1'(pc); exp_data = pd; exp_mask = pm;
      act_valid = a; act_chan = 1'(ac); act_data = ad;
      if (a) begin
         if (q[ac].size() > 0) begin
            h = q[ac].pop_front();
            if (((ad ^ h[W-1:0]) & h[2*W-1:W]) == '0) m_match = sat(m_match + 1);
            else begin m_mism = sat(m_mism + 1); aerr = 1; end
         end else begin
            m_unexp = sat(m_unexp + 1);
            aerr = 1;
         end
      end
      if (p) begin
         if (q[pc].size() == 4) begin m_ovf = sat(m_ovf + 1); perr = 1; end
         else q[pc].push_back({pm, pd});
      end
      if (tev) m_tmo = sat(m_tmo + 1);
      m_ev = aerr | perr | tev;
      m_echan = aerr ? ac : perr ? pc : tev ? 0 : m_echan;
      @(posedge clk);
      #1;
      exp_push = 1'b0;
      act_valid = 1'b0;
      check_state();
   endtask

   task automatic idle_step();
      step(0, 0, '0, '0, 0, 0, '0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_state();
      // in-order match on ch0
      step(1, 0, rep(8'hA5), ONES, 0, 0, '0);
      step(1, 0, rep(8'h3C), ONES, 0, 0, '0);
      step(0, 0, '0, '0, 1, 0, rep(8'hA5));
      step(0, 0, '0, '0, 1, 0, rep(8'h3C));
      // masked compare on ch1: low nibble ignored, then a masked bit differs
      step(1, 1, 256'h00FF, 256'h00F0, 0, 0, '0);
      step(0, 0, '0, '0, 1, 1, 256'h00F5);
      step(1, 1, 256'h00FF, 256'h00F0, 0, 0, '0);
      step(0, 0, '0, '0, 1, 1, 256'h00EF);
      idle_step();
      // fill ch0, overflow, then push+pop while full
      for (int k = 1; k <= 5; k++) step(1, 0, rep(8'(k)), ONES, 0, 0, '0);
      step(1, 0, rep(8'h06), ONES, 1, 0, rep(8'h01));
      step(0, 0, '0, '0, 1, 0, rep(8'h02));
      step(0, 0, '0, '0, 1, 0, rep(8'h03));
      step(0, 0, '0, '0, 1, 0, rep(8'h04));
      step(0, 0, '0, '0, 1, 0, rep(8'h06));
      // push and act together on empty ch1: no bypass
      step(1, 1, rep(8'h77), ONES, 1, 1, rep(8'h77));
      step(0, 0, '0, '0, 1, 1, rep(8'h77));
      // head ages out after TIMEOUT-1 cycles, once
      step(1, 0, rep(8'h5A), ONES, 0, 0, '0);
      for (int i = 1; i <= 40; i++) begin
         tev = (i == 15);
         idle_step();
         tev = 1'b0;
      end
      step(0, 0, '0, '0, 1, 0, rep(8'h5A));
      for (int i = 0; i < 20; i++) idle_step();
      // unexpected counter saturates
      for (int i = 0; i < 20; i++) step(0, 0, '0, '0, 1, 1, rep(8'h11));
      // clear with words queued and a same-cycle push
      for (int k = 0; k < 3; k++) step(1, 0, rep(8'(8'h20 + k)), ONES, 0, 0, '0);
      exp_push = 1'b1; exp_chan = '0; exp_data = rep(8'h99); exp_mask = ONES; clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      exp_push = 1'b0;
      q[0].delete();
      q[1].delete();
      m_match = 0; m_mism = 0; m_unexp = 0; m_ovf = 0; m_tmo = 0; m_echan = 0; m_ev = 1'b0;
      check_state();
      step(0, 0, '0, '0, 1, 0, rep(8'h20));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
